count8_down: RTL and testbench

Synchronous 8-bit loadable down counter with terminal-count pulse, the decrementing counterpart of the team's 8-bit up counter. It loads a start value, counts down by one per enabled clock, and flags the step from 0x01 to 0x00. Used as the countdown and timeout element next to the memory-unit up counter, for example for burst lengths, wait states and refresh intervals. Built from the shared gate-level components and D flip-flops, following the existing counter structure.

---
 rtl/count8_down.sv | 88 ++++++++
 tb/tb_count8_down.sv | 135 +++++++++++++
 2 files changed

// File: rtl/count8_down.sv
// 8-bit loadable down counter with registered terminal-count pulse.
// Optional macro COUNT8_DOWN_RELOAD_EN: reload from the last loaded value on expiry instead of wrapping.
module count8_down (
   input  logic       clk,
   input  logic       res,
   input  logic [7:0] CNT_In,
   input  logic       load,
   input  logic       EN,
   output logic [7:0] CNT,
   output logic       ZERO,
   output logic       TC
);

   typedef enum logic {
      ST_RUN,
      ST_EXPIRED
   } state_e;

   logic [7:0] cnt_q, cnt_d;
   logic       tc_q, tc_d;
   logic [7:0] tgl;
   state_e     state;

`ifdef COUNT8_DOWN_RELOAD_EN
   logic [7:0] rld_q, rld_d;
`endif

   // Counter state is fully determined by the count value; no separate state flops.
   always_comb state = (cnt_q == '0) ? ST_EXPIRED : ST_RUN;

   // Borrow chain: a bit toggles when every lower bit is already zero.
   assign tgl[0] = EN;
   for (genvar i = 0; i < 7; i++) begin : g_borrow
      assign tgl[i+1] = tgl[i] & ~cnt_q[i];
   end

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
`ifdef COUNT8_DOWN_RELOAD_EN
      rld_d = rld_q;
`endif
      if (load) begin
         cnt_d = CNT_In;
`ifdef COUNT8_DOWN_RELOAD_EN
         rld_d = CNT_In;
`endif
      end else if (EN) begin
         unique case (state)
            ST_RUN: begin
               cnt_d = cnt_q ^ tgl;
               tc_d  = (cnt_q == 8'h01);
            end
            ST_EXPIRED: begin
`ifdef COUNT8_DOWN_RELOAD_EN
               cnt_d = rld_q;
`else
               // All-zero count makes every toggle term active: wraps to 0xFF.
               cnt_d = cnt_q ^ tgl;
`endif
            end
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

`ifdef COUNT8_DOWN_RELOAD_EN
   always_ff @(posedge clk) begin
      if (!res) rld_q <= '0;
      else      rld_q <= rld_d;
   end
`endif

   assign CNT  = cnt_q;
   assign ZERO = (cnt_q == '0);
   assign TC   = tc_q;

endmodule

// File: tb/tb_count8_down.sv
// Randomized and directed self-checking bench for count8_down against an arithmetic reference model.
// Model follows COUNT8_DOWN_RELOAD_EN the same way the design does.
module tb_count8_down;

   logic       clk;
   logic       res;
   logic [7:0] CNT_In;
   logic       load;
   logic       EN;
   logic [7:0] CNT;
   logic       ZERO;
   logic       TC;

   int unsigned total = 0;
   int unsigned bad   = 0;

   int m_cnt = 0;
   int m_rld = 0;
   int m_tc  = 0;

   count8_down dut (
      .clk   (clk),
      .res   (res),
      .CNT_In(CNT_In),
      .load  (load),
      .EN    (EN),
      .CNT   (CNT),
      .ZERO  (ZERO),
      .TC    (TC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge: apply inputs, advance the model, compare just after the edge.
   task automatic step(input logic r, input logic ld, input logic en, input logic [7:0] din,
                       input string tag);
      @(negedge clk);
      res    = r;
      load   = ld;
      EN     = en;
      CNT_In = din;
      @(posedge clk);
      if (!r) begin
         m_cnt = 0;
         m_rld = 0;
         m_tc  = 0;
      end else if (ld) begin
         m_cnt = din;
         m_rld = din;
         m_tc  = 0;
      end else if (en) begin
         m_tc = (m_cnt == 1) ? 1 : 0;
         if (m_cnt != 0) m_cnt = m_cnt - 1;
`ifdef COUNT8_DOWN_RELOAD_EN
         else m_cnt = m_rld;
`else
         else m_cnt = 255;
`endif
      end else begin
         m_tc = 0;
      end
      #1;
      check({tag, ".cnt"},  int'(CNT),  m_cnt);
      check({tag, ".zero"}, int'(ZERO), (m_cnt == 0) ? 1 : 0);
      check({tag, ".tc"},   int'(TC),   m_tc);
   endtask

   initial begin
      res = 1'b1; load = 1'b0; EN = 1'b0; CNT_In = '0;

      // Reset dominates a simultaneous load.
      step(1'b0, 1'b1, 1'b0, 8'h55, "reset");
      check("reset_const_cnt", int'(CNT), 0);
      check("reset_const_zero", int'(ZERO), 1);

      // Load and count to terminal.
      step(1'b1, 1'b1, 1'b0, 8'h03, "load3");
      step(1'b1, 1'b0, 1'b1, 8'h00, "dec_a");
      step(1'b1, 1'b0, 1'b1, 8'h00, "dec_b");
      step(1'b1, 1'b0, 1'b1, 8'h00, "dec_c");
      check("tc_at_zero", int'(TC), 1);
      step(1'b1, 1'b0, 1'b0, 8'h00, "hold0");

      // Load beats enable; loading 0x01 gives no pulse.
      step(1'b1, 1'b1, 1'b1, 8'h10, "prio10");
      step(1'b1, 1'b1, 1'b1, 8'h01, "prio01");
      check("prio_no_tc", int'(TC), 0);

      // Long borrow, then load of zero.
      step(1'b1, 1'b1, 1'b0, 8'h80, "load80");
      step(1'b1, 1'b0, 1'b1, 8'h00, "borrow");
      check("borrow_7f", int'(CNT), 8'h7F);
      step(1'b1, 1'b1, 1'b0, 8'h00, "load00");

      // Expiry behaviour.
      step(1'b1, 1'b1, 1'b0, 8'h02, "load2");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "expiry");
`ifdef COUNT8_DOWN_RELOAD_EN
      check("reload_end", int'(CNT), 8'h01);
`else
      check("wrap_end", int'(CNT), 8'hFB);
`endif

      // Reset mid-count.
      step(1'b1, 1'b1, 1'b0, 8'hA0, "loadA0");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "run");
      check("mid_9b", int'(CNT), 8'h9B);
      step(1'b0, 1'b0, 1'b1, 8'h00, "midres");
      step(1'b1, 1'b0, 1'b1, 8'h00, "after");

      // Random traffic; small load values exercise terminal count often.
      for (int i = 0; i < 400; i++) begin
         logic       r, ld, en;
         logic [7:0] d;
         r  = ($urandom_range(0, 31) != 0);
         ld = ($urandom_range(0, 7) == 0);
         en = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         step(r, ld, en, d, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
